// File: rtl/program_loader.sv
// Byte-stream program loader: accepts SYNC, LEN, DATA..., CSUM frames, writes the
// data bytes into the machine RAM and releases the CPU once the checksum verifies.
module program_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]        SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   bytes_loaded
);

    localparam int                CW         = ADDR_W + 1;
    localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE    = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE    = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_remaining;
    logic [7:0]          r_sum;
    logic [ADDR_W:0]     r_bytesLoaded;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [7:0]          r_memData;

    logic                w_xfer;
    logic                w_isSync;
    logic [ADDR_W:0]     w_lenCount;

    // Status outputs are pure functions of the state, so they change exactly one
    // clock after the transfer or reload that caused the transition.
    assign in_ready     = (r_state != S_DONE);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERROR);
    assign cpu_hold     = (r_state != S_DONE);
    assign mem_we       = r_memWe;
    assign mem_addr     = r_memAddr;
    assign mem_data     = r_memData;
    assign bytes_loaded = r_bytesLoaded;

    assign w_xfer     = in_valid && in_ready;
    assign w_isSync   = (in_data == SYNC_BYTE);
    assign w_lenCount = (in_data == 8'd0) ? FULL_COUNT : CW'(in_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A SYNC byte arriving in ERROR wins over a simultaneous reload so it is not lost.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && w_isSync) w_nextState = S_LEN;
            end
            S_LEN: begin
                if (w_xfer) w_nextState = S_DATA;
            end
            S_DATA: begin
                if (w_xfer && (r_remaining == CNT_ONE)) w_nextState = S_CSUM;
            end
            S_CSUM: begin
                if (w_xfer) w_nextState = (in_data == r_sum) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                if (reload) w_nextState = S_IDLE;
            end
            S_ERROR: begin
                if (w_xfer && w_isSync) w_nextState = S_LEN;
                else if (reload)        w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr         <= BASE_ADDR;
            r_remaining   <= '0;
            r_sum         <= '0;
            r_bytesLoaded <= '0;
            r_memWe       <= 1'b0;
            r_memAddr     <= BASE_ADDR;
            r_memData     <= '0;
        end else begin
            r_memWe <= 1'b0;
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (w_xfer && w_isSync) begin
                        r_bytesLoaded <= '0;
                        r_ptr         <= BASE_ADDR;
                    end
                end
                S_LEN: begin
                    if (w_xfer) begin
                        r_remaining <= w_lenCount;
                        r_sum       <= in_data;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_memWe       <= 1'b1;
                        r_memAddr     <= r_ptr;
                        r_memData     <= in_data;
                        r_ptr         <= r_ptr + PTR_ONE;
                        r_bytesLoaded <= r_bytesLoaded + CNT_ONE;
                        r_sum         <= r_sum + in_data;
                        r_remaining   <= r_remaining - CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (reload) r_ptr <= BASE_ADDR;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomised scoreboard bench for program_loader: frames are built from a
// frame-level model, expected RAM writes and outcomes are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_program_loader;

    localparam int         ADDR_W = 8;
    localparam logic [7:0] BASE   = 8'hF0;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [8:0]  bytes_loaded;

    program_loader #(
        .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .reload(reload),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .bytes_loaded(bytes_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cycle;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int         cycle;
        logic       done;
        logic       error;
        logic [8:0] bytes;
    } res_t;

    wr_t        wrQ[$];
    res_t       resQ[$];
    logic [7:0] frameData[$];
    int         checks = 0;
    int         errors = 0;
    bit         gapMode = 0;
    bit         lastDone = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every write and every frame outcome must appear on exactly the predicted cycle.
    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        if (mem_we) begin
            if (wrQ.size() == 0) begin
                checkOutput("write when none expected", {31'd0, mem_we}, 32'd0);
            end else begin
                w = wrQ.pop_front();
                checkOutput("write cycle", cyc, w.cycle);
                checkOutput("write addr", {24'd0, mem_addr}, {24'd0, w.addr});
                checkOutput("write data", {24'd0, mem_data}, {24'd0, w.data});
            end
        end else if (wrQ.size() > 0 && wrQ[0].cycle <= cyc) begin
            w = wrQ.pop_front();
            checkOutput("missing write", {31'd0, mem_we}, 32'd1);
        end
        if (resQ.size() > 0 && resQ[0].cycle <= cyc) begin
            r = resQ.pop_front();
            checkOutput("outcome cycle", cyc, r.cycle);
            checkOutput("done", {31'd0, done}, {31'd0, r.done});
            checkOutput("error", {31'd0, error}, {31'd0, r.error});
            checkOutput("cpu_hold", {31'd0, cpu_hold}, {31'd0, !r.done});
            checkOutput("bytes_loaded", {23'd0, bytes_loaded}, {23'd0, r.bytes});
        end
    end

    task automatic sendByte(input logic [7:0] b, output int xferCyc);
        int waitN;
        waitN = 0;
        @(negedge clk);
        while (gapMode && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waitN < 50) begin
            waitN++;
            @(negedge clk);
        end
        if (!in_ready) checkOutput("in_ready timeout", {31'd0, in_ready}, 32'd1);
        xferCyc = cyc;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Sends one frame built from frameData; csumOverride < 0 means a correct or
    // (if corrupt) deliberately wrong checksum.
    task automatic applyStimulus(input bit corrupt, input int csumOverride, input int garbage);
        int         c;
        int         n;
        logic [7:0] lenByte;
        logic [7:0] sum;
        logic [7:0] csum;
        logic [7:0] x;
        wr_t        w;
        res_t       r;
        for (int g = 0; g < garbage; g++) begin
            do x = 8'($urandom_range(0, 255)); while (x == SYNC);
            sendByte(x, c);
        end
        n       = frameData.size();
        lenByte = (n == 256) ? 8'd0 : 8'(n);
        sendByte(SYNC, c);
        sendByte(lenByte, c);
        sum = lenByte;
        for (int i = 0; i < n; i++) begin
            sendByte(frameData[i], c);
            w.cycle = c + 1;
            w.addr  = BASE + 8'(i);
            w.data  = frameData[i];
            wrQ.push_back(w);
            sum = sum + frameData[i];
        end
        if (csumOverride >= 0) csum = 8'(csumOverride);
        else if (corrupt)      csum = sum ^ 8'($urandom_range(1, 255));
        else                   csum = sum;
        sendByte(csum, c);
        r.cycle = c + 1;
        r.done  = (csum == sum);
        r.error = (csum != sum);
        r.bytes = 9'(n);
        resQ.push_back(r);
        idle();
        lastDone = (csum == sum);
    endtask

    task automatic pulseReload();
        @(negedge clk);
        in_valid = 1'b0;
        reload   = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        checkOutput("reload cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("reload in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reload done", {31'd0, done}, 32'd0);
        checkOutput("reload error", {31'd0, error}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  c;
        wr_t w;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset error", {31'd0, error}, 32'd0);
        checkOutput("reset mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset mem_addr", {24'd0, mem_addr}, {24'd0, BASE});
        checkOutput("reset mem_data", {24'd0, mem_data}, 32'd0);
        checkOutput("reset bytes_loaded", {23'd0, bytes_loaded}, 32'd0);
        reset = 1'b0;

        $display("[TB] basic load");
        frameData = '{8'h10, 8'h20, 8'h30};
        applyStimulus(0, -1, 0);

        $display("[TB] backpressure in DONE");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = SYNC;
        repeat (4) begin
            @(negedge clk);
            checkOutput("in_ready in DONE", {31'd0, in_ready}, 32'd0);
        end
        checkOutput("done held", {31'd0, done}, 32'd1);
        checkOutput("bytes_loaded held", {23'd0, bytes_loaded}, 32'd3);
        pulseReload();

        $display("[TB] bad checksum then recovery");
        frameData = '{8'hAA, 8'hBB};
        applyStimulus(0, 8'h00, 0);
        frameData = '{8'h07};
        applyStimulus(0, -1, 0);
        pulseReload();

        $display("[TB] garbage and gaps");
        gapMode = 1;
        sendByte(8'h11, c);
        sendByte(8'h22, c);
        frameData = '{8'hFF};
        applyStimulus(0, 8'h00, 0);
        gapMode = 0;
        pulseReload();

        $display("[TB] full image with address wrap");
        frameData.delete();
        for (int i = 0; i < 256; i++) frameData.push_back(8'(i));
        applyStimulus(0, 8'h80, 0);
        pulseReload();

        $display("[TB] reset mid-frame");
        sendByte(SYNC, c);
        sendByte(8'd4, c);
        for (int i = 0; i < 2; i++) begin
            sendByte(8'h5A + 8'(i), c);
            w.cycle = c + 1;
            w.addr  = BASE + 8'(i);
            w.data  = 8'h5A + 8'(i);
            wrQ.push_back(w);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("midreset mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("midreset bytes_loaded", {23'd0, bytes_loaded}, 32'd0);
        checkOutput("midreset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midreset mem_addr", {24'd0, mem_addr}, {24'd0, BASE});
        frameData = '{8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(0, -1, 0);

        $display("[TB] randomised frames");
        for (int f = 0; f < 8; f++) begin
            if (lastDone || $urandom_range(0, 1) == 1) pulseReload();
            frameData.delete();
            for (int i = 0; i < int'($urandom_range(1, 24)); i++) frameData.push_back(8'($urandom_range(0, 255)));
            gapMode = ($urandom_range(0, 1) == 1);
            applyStimulus($urandom_range(0, 2) == 0, -1, int'($urandom_range(0, 3)));
        end
        gapMode = 0;

        repeat (5) @(negedge clk);
        checkOutput("write queue drained", wrQ.size(), 32'd0);
        checkOutput("outcome queue drained", resQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
